led_matrix_scanner: RTL
=======================

LED_MATRIX_SCANNER -- requirements
Module: led_matrix_scanner

Interface
REQ-001 Parameter ROWS, default 16, number of matrix rows (>=2).
REQ-002 Parameter COLS, default 16, number of matrix columns (>=1).
REQ-003 Parameter DWELL, default 32, drive cycles per row (>=1).
REQ-004 Parameter BLANK, default 2, blanking cycles before each row (>=1).
REQ-005 CLK  in  1  system clock (the divided board clock); all state on its rising edge.
REQ-006 RST  in  1  reset, asynchronous and active-high.
REQ-007 EN  in  1  scan enable; 0 forces idle.
REQ-008 BRIGHT  in  $clog2(DWELL+1)  PWM on-cycles within each row's dwell.
REQ-009 RedPixels  in  [ROWS-1:0][COLS-1:0]  red frame source, 1 = lit.
REQ-010 GrnPixels  in  [ROWS-1:0][COLS-1:0]  green frame source, 1 = lit.
REQ-011 row_sel  out  ROWS  one-hot active-high row drive.
REQ-012 red_col  out  COLS  red column drive for the selected row.
REQ-013 grn_col  out  COLS  green column drive for the selected row.
REQ-014 frame_start  out  1  one-cycle pulse at the start of each frame.
REQ-015 row_idx  out  $clog2(ROWS)  index of the row being blanked or driven.

Function
REQ-016 FSM states SHALL be IDLE, BLANK and DRIVE.
REQ-017 All outputs SHALL be registered.
REQ-018 IDLE: row_sel, red_col, grn_col, frame_start and row_idx SHALL all be 0.
REQ-019 IDLE with EN=1 SHALL transition to BLANK with row_idx=0.
REQ-020 Entering BLANK for row 0 SHALL capture RedPixels/GrnPixels into a shadow frame buffer and assert frame_start for exactly that first BLANK cycle.
REQ-021 Input frame changes after capture SHALL NOT affect outputs until the next frame capture (no tearing).
REQ-022 BLANK SHALL last exactly BLANK cycles with row_sel=0, red_col=0, grn_col=0, then transition to DRIVE.
REQ-023 BRIGHT SHALL be sampled on the last BLANK cycle and held for the following DRIVE period.
REQ-024 DRIVE SHALL last exactly DWELL cycles.
REQ-025 Throughout DRIVE, row_sel SHALL equal one-hot(row_idx).
REQ-026 In DRIVE cycle k (k = 0..DWELL-1), red_col/grn_col SHALL equal shadow row row_idx if k < sampled BRIGHT, else 0.
REQ-027 BRIGHT=0 SHALL give a dark row; BRIGHT>=DWELL SHALL give full-on for all DWELL cycles.
REQ-028 After the last DRIVE cycle, row_idx SHALL increment and the FSM SHALL enter BLANK.
REQ-029 After row ROWS-1, row_idx SHALL wrap to 0 and REQ-020 (capture and frame_start) SHALL apply.
REQ-030 Frame period SHALL be exactly ROWS*(BLANK+DWELL) cycles; frame_start pulses SHALL be that far apart.
REQ-031 EN=0 in any state SHALL cause IDLE on the next cycle, abandoning the current row.
REQ-032 Re-enable SHALL always restart at row 0 with a fresh capture.
REQ-033 Red and green for the same pixel SHALL be drivable simultaneously (amber); no arbitration.

Reset
REQ-034 RST=1 SHALL immediately (asynchronously) force IDLE, all outputs 0, all counters 0, and shadow buffer 0.
REQ-035 RST asserted mid-DRIVE SHALL drop row_sel/red_col/grn_col to 0 without waiting for a clock edge.
REQ-036 After RST deasserts with EN=1, the first frame_start SHALL occur on the second rising edge.

Verification (ROWS=4, COLS=4, DWELL=4, BLANK=1)
REQ-037 Reset release, EN=1, BRIGHT=4, Red row0=4'b0001, Grn=0 -> frame_start pulse; 1 blank cycle; 4 cycles row_sel=4'b0001, red_col=4'b0001; frame_start again 20 cycles later.
REQ-038 BRIGHT=2, all pixels red -> each DRIVE: red_col=4'hF for 2 cycles, then 0 for 2; BRIGHT=0 -> red_col always 0.
REQ-039 Change RedPixels while row 2 is driven -> rows 2-3 show the old frame; the new frame appears only after the next frame_start.
REQ-040 EN dropped during row 1 DRIVE -> next cycle all outputs 0; EN re-raised -> frame_start with row_idx=0.
REQ-041 RST pulsed between clock edges mid-DRIVE -> outputs 0 with no clock edge; shadow buffer cleared.
REQ-042 Red and green both set at pixel (3,0) -> during row 3 DRIVE, red_col[0]=grn_col[0]=1; row_idx wraps 3->0.

Source files
------------

// File: rtl/led_matrix_scanner.sv
// Row-multiplexed scanner for a red/green LED matrix: shadow frame buffer,
// per-row blanking and PWM brightness, with registered row/column drives.
module led_matrix_scanner #(
  parameter int ROWS  = 16,
  parameter int COLS  = 16,
  parameter int DWELL = 32,
  parameter int BLANK = 2
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic                           EN,
  input  logic [$clog2(DWELL+1)-1:0]     BRIGHT,
  input  logic [ROWS-1:0][COLS-1:0]      RedPixels,
  input  logic [ROWS-1:0][COLS-1:0]      GrnPixels,
  output logic [ROWS-1:0]                row_sel,
  output logic [COLS-1:0]                red_col,
  output logic [COLS-1:0]                grn_col,
  output logic                           frame_start,
  output logic [$clog2(ROWS)-1:0]        row_idx
);

  localparam int BW   = $clog2(DWELL + 1);
  localparam int RW   = $clog2(ROWS);
  localparam int MAXC = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int CW   = $clog2(MAXC + 1);

  // state   | meaning
  // S_IDLE  | scan stopped, all drives low
  // S_BLANK | row selected internally, drives forced low for BLANK cycles
  // S_DRIVE | row driven for DWELL cycles, columns lit while PWM budget remains
  typedef enum logic [1:0] {S_IDLE, S_BLANK, S_DRIVE} state_t;

  state_t                    state_q, state_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [RW-1:0]             row_q, row_d;
  logic [BW-1:0]             on_q, on_d;
  logic [BW-1:0]             eff_on;
  logic [ROWS-1:0][COLS-1:0] red_sh_q, red_sh_d;
  logic [ROWS-1:0][COLS-1:0] grn_sh_q, grn_sh_d;

  logic [ROWS-1:0]           row_sel_q, row_sel_d;
  logic [COLS-1:0]           red_col_q, red_col_d;
  logic [COLS-1:0]           grn_col_q, grn_col_d;
  logic                      frame_start_q, frame_start_d;
  logic [RW-1:0]             row_idx_q, row_idx_d;

  // On the first drive cycle BRIGHT is taken directly, so the value held
  // during the last blank cycle sets the on-time of the whole dwell.
  assign eff_on = (state_q == S_DRIVE && cnt_q == CW'(DWELL - 1)) ? BRIGHT : on_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      row_q         <= '0;
      on_q          <= '0;
      red_sh_q      <= '0;
      grn_sh_q      <= '0;
      row_sel_q     <= '0;
      red_col_q     <= '0;
      grn_col_q     <= '0;
      frame_start_q <= 1'b0;
      row_idx_q     <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      row_q         <= row_d;
      on_q          <= on_d;
      red_sh_q      <= red_sh_d;
      grn_sh_q      <= grn_sh_d;
      row_sel_q     <= row_sel_d;
      red_col_q     <= red_col_d;
      grn_col_q     <= grn_col_d;
      frame_start_q <= frame_start_d;
      row_idx_q     <= row_idx_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    row_d    = row_q;
    on_d     = on_q;
    red_sh_d = red_sh_q;
    grn_sh_d = grn_sh_q;
    case (state_q)
      S_IDLE: begin
        if (EN) begin
          state_d  = S_BLANK;
          cnt_d    = CW'(BLANK - 1);
          row_d    = '0;
          red_sh_d = RedPixels;
          grn_sh_d = GrnPixels;
        end
      end
      S_BLANK: begin
        if (cnt_q == '0) begin
          state_d = S_DRIVE;
          cnt_d   = CW'(DWELL - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DRIVE: begin
        on_d = (eff_on != '0) ? eff_on - 1'b1 : '0;
        if (cnt_q == '0) begin
          state_d = S_BLANK;
          cnt_d   = CW'(BLANK - 1);
          if (row_q == RW'(ROWS - 1)) begin
            row_d    = '0;
            red_sh_d = RedPixels;
            grn_sh_d = GrnPixels;
          end else begin
            row_d = row_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (!EN) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      row_d   = '0;
      on_d    = '0;
    end
  end

  always_comb begin
    row_sel_d     = '0;
    red_col_d     = '0;
    grn_col_d     = '0;
    frame_start_d = 1'b0;
    row_idx_d     = '0;
    if (EN) begin
      case (state_q)
        S_BLANK: begin
          row_idx_d     = row_q;
          frame_start_d = (row_q == '0) && (cnt_q == CW'(BLANK - 1));
        end
        S_DRIVE: begin
          row_idx_d        = row_q;
          row_sel_d[row_q] = 1'b1;
          if (eff_on != '0) begin
            red_col_d = red_sh_q[row_q];
            grn_col_d = grn_sh_q[row_q];
          end
        end
        default: ;
      endcase
    end
  end

  assign row_sel     = row_sel_q;
  assign red_col     = red_col_q;
  assign grn_col     = grn_col_q;
  assign frame_start = frame_start_q;
  assign row_idx     = row_idx_q;

endmodule
